alu_operand_sequencer: RTL and testbench
========================================

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 The block SHALL have one parameter: FUNC_MAX, default 5, the highest legal function code.
REQ-002 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 Resetn  input  1  reset, asynchronous, active-low.
REQ-004 Data  input  4  operand/function value, static while Load is high.
REQ-005 Load  input  1  raw active-high load request, asynchronous to Clock.
REQ-006 Abort  input  1  synchronous active-high cancel of the current sequence.
REQ-007 OpReady  input  1  downstream ALU stage accepts the operand set.
REQ-008 A  output  4  registered operand A.
REQ-009 B  output  4  registered operand B.
REQ-010 Func  output  3  registered ALU function select.
REQ-011 OpValid  output  1  operand set complete and stable.
REQ-012 Err  output  1  sticky illegal-function flag.
REQ-013 State  output  2  current FSM state encoding.
REQ-014 OpCount  output  8  count of operand sets accepted downstream.

Function
REQ-015 Load SHALL pass through a 2-flop synchronizer (s1, s2) and a third flop s3; load pulse = s2 & ~s3, exactly one cycle per Load rising edge.
REQ-016 Capture latency SHALL be 3 rising edges: Load high before edge 1 -> target register written at edge 3.
REQ-017 FSM states SHALL be S_A=2'd0, S_B=2'd1, S_F=2'd2, S_ISSUE=2'd3, driven on State.
REQ-018 S_A: load pulse -> A <= Data, go S_B; otherwise hold.
REQ-019 S_B: load pulse -> B <= Data, go S_F; otherwise hold.
REQ-020 S_F: load pulse with Data[3]=0 and Data[2:0] <= FUNC_MAX -> Func <= Data[2:0], Err <= 0, go S_ISSUE.
REQ-021 S_F: load pulse with Data[3]=1 or Data[2:0] > FUNC_MAX -> Func unchanged, Err <= 1, stay S_F.
REQ-022 OpValid SHALL be 1 exactly when State = S_ISSUE (registered, no combinational path from inputs).
REQ-023 S_ISSUE: OpReady=1 sampled at an edge -> go S_A, OpCount <= OpCount+1; OpReady=0 -> hold.
REQ-024 A, B, Func SHALL not change while OpValid=1.
REQ-025 Load pulses in S_ISSUE SHALL be ignored (no register, state, or Err change).
REQ-026 OpCount SHALL wrap 8'hFF -> 8'h00 without other effect.
REQ-027 Abort=1 at an edge SHALL force S_A from any state; A, B, Func, OpCount, Err retain values; OpValid low after that edge.
REQ-028 Abort and a load pulse in the same cycle: Abort wins, pulse discarded.
REQ-029 Abort and OpReady both 1 in S_ISSUE: Abort wins, OpCount not incremented.
REQ-030 OpReady outside S_ISSUE SHALL have no effect.

Reset
REQ-031 Resetn=0 SHALL immediately force A=0, B=0, Func=0, OpValid=0, Err=0, State=S_A, OpCount=0, s1=s2=s3=0.
REQ-032 Load held high across reset release SHALL produce one load pulse (s3 resets to 0), capturing A at edge 3 after release.
REQ-033 Reset asserted mid-sequence (any state, including S_ISSUE with OpReady=0) SHALL discard the sequence; no partial values remain.

Verification
REQ-034 Load edges with Data=4'h3, 4'hA, 4'h1; OpReady=0 -> A=3, B=A(hex), Func=1, OpValid=1 held, State=3; then OpReady=1 one cycle -> OpValid=0, State=0, OpCount=1.
REQ-035 In S_F, Load with Data=4'h7 then 4'h9 -> Err=1, State=2 after each; then Data=4'h4 -> Func=4, Err=0, OpValid=1.
REQ-036 Load high for 1 cycle between edges -> exactly one capture at edge 3; Load held high 20 cycles -> one capture only.
REQ-037 Abort=1 same cycle as load pulse in S_B -> State=0, B unchanged, OpValid=0; Abort+OpReady in S_ISSUE -> OpCount unchanged.
REQ-038 255 full sequences then one more -> OpCount=8'hFF then 8'h00; Load pulse in S_ISSUE -> A, B, Func unchanged.
REQ-039 Resetn low during S_ISSUE with A=F, B=F -> all outputs 0 asynchronously, before next Clock edge.

Source files
------------

// File: rtl/alu_operand_sequencer_if.sv
// Operand-sequencer bus: load/abort/handshake inputs and the registered
// operand set, status and counters presented to the downstream ALU stage.
//   Data    [3:0] operand / function value, static while Load is high
//   Load          raw load request (asynchronous to the sequencer clock)
//   Abort         synchronous cancel of the current sequence
//   OpReady       downstream stage accepts the operand set
//   A, B    [3:0] operands
//   Func    [2:0] ALU function select
//   OpValid       operand set complete and stable
//   Err           sticky illegal-function flag
//   State   [1:0] current sequencer state
//   OpCount [7:0] operand sets accepted downstream (wraps)
interface alu_operand_sequencer_if;
  logic [3:0] Data;
  logic       Load;
  logic       Abort;
  logic       OpReady;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] Func;
  logic       OpValid;
  logic       Err;
  logic [1:0] State;
  logic [7:0] OpCount;

  // Sequencer side
  modport slave (
    input  Data, Load, Abort, OpReady,
    output A, B, Func, OpValid, Err, State, OpCount
  );

  // Producer / consumer side
  modport master (
    output Data, Load, Abort, OpReady,
    input  A, B, Func, OpValid, Err, State, OpCount
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects operand A, operand B and a function code from successive Load
// requests on a shared 4-bit Data bus, then presents the complete set to the
// downstream ALU stage until it is accepted with OpReady.
//   Clock   system clock, rising edge
//   Resetn  asynchronous active-low reset
//   bus     alu_operand_sequencer_if.slave (see interface for signal list)
// Parameter FUNC_MAX: highest legal function code.
module alu_operand_sequencer #(
  parameter int unsigned FUNC_MAX = 5
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  alu_operand_sequencer_if.slave  bus
);

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned FUNC_W  = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_F     = 2'd2,
    S_ISSUE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic                load_pulse;
  logic                func_legal;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [FUNC_W-1:0]   func_q, func_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                opvalid_q;

  // Load synchronizer plus edge-detect flop; s3 resets low so a Load held
  // across reset release still yields exactly one pulse.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.Load;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign load_pulse = s2_q & ~s3_q;

  // Function code is legal only with the top bit clear and within range.
  assign func_legal = ~bus.Data[3] &&
                      (32'(bus.Data[FUNC_W-1:0]) <= FUNC_MAX);

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Abort overrides any load pulse or handshake.
  always_comb begin
    state_d = state_q;
    if (bus.Abort) begin
      state_d = S_A;
    end else begin
      case (state_q)
        S_A:     if (load_pulse)               state_d = S_B;
        S_B:     if (load_pulse)               state_d = S_F;
        S_F:     if (load_pulse && func_legal) state_d = S_ISSUE;
        S_ISSUE: if (bus.OpReady)              state_d = S_A;
        default:                               state_d = S_A;
      endcase
    end
  end

  // Datapath next values; registers only move on the state that owns them,
  // so the operand set is frozen while it is being issued.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    func_d = func_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (!bus.Abort) begin
      case (state_q)
        S_A: if (load_pulse) a_d = bus.Data;
        S_B: if (load_pulse) b_d = bus.Data;
        S_F: begin
          if (load_pulse) begin
            if (func_legal) begin
              func_d = bus.Data[FUNC_W-1:0];
              err_d  = 1'b0;
            end else begin
              err_d  = 1'b1;
            end
          end
        end
        S_ISSUE: if (bus.OpReady) cnt_d = cnt_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Datapath and status registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      opvalid_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      func_q    <= func_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      opvalid_q <= (state_d == S_ISSUE);
    end
  end

  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.Func    = func_q;
  assign bus.Err     = err_q;
  assign bus.OpCount = cnt_q;
  assign bus.OpValid = opvalid_q;
  assign bus.State   = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer.
module tb_alu_operand_sequencer;

  logic Clock = 1'b0;
  logic Resetn;

  always #5 Clock = ~Clock;

  alu_operand_sequencer_if bus();

  alu_operand_sequencer #(.FUNC_MAX(5)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] data;
    logic       rdy;    // pulse OpReady after this load
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] func;
    logic       err;
    logic [1:0] state;
    logic       valid;
  } vec_t;

  vec_t       vecs [16];
  vec_t       sb_q [$];
  vec_t       exp_v;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic [2:0] ef, input logic ev, input logic ee,
                           input logic [1:0] es, input logic [7:0] ec);
    chk({tag, ".A"},       8'(bus.A),       8'(ea));
    chk({tag, ".B"},       8'(bus.B),       8'(eb));
    chk({tag, ".Func"},    8'(bus.Func),    8'(ef));
    chk({tag, ".OpValid"}, 8'(bus.OpValid), 8'(ev));
    chk({tag, ".Err"},     8'(bus.Err),     8'(ee));
    chk({tag, ".State"},   8'(bus.State),   8'(es));
    chk({tag, ".OpCount"}, bus.OpCount,     ec);
  endtask

  // One Load request high for a single cycle; returns after capture settles.
  task automatic do_load(input logic [3:0] d);
    @(negedge Clock);
    bus.Data = d;
    bus.Load = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.Load = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic pulse_ready();
    @(negedge Clock);
    bus.OpReady = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.OpReady = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    //            data  rdy  a     b     f     e     st    v
    vecs[0]  = '{4'h3, 1'b0, 4'h3, 4'h0, 3'd0, 1'b0, 2'd1, 1'b0};
    vecs[1]  = '{4'hA, 1'b0, 4'h3, 4'hA, 3'd0, 1'b0, 2'd2, 1'b0};
    vecs[2]  = '{4'h1, 1'b0, 4'h3, 4'hA, 3'd1, 1'b0, 2'd3, 1'b1};
    vecs[3]  = '{4'h8, 1'b1, 4'h3, 4'hA, 3'd1, 1'b0, 2'd3, 1'b1};
    vecs[4]  = '{4'h2, 1'b0, 4'h2, 4'hA, 3'd1, 1'b0, 2'd1, 1'b0};
    vecs[5]  = '{4'hF, 1'b0, 4'h2, 4'hF, 3'd1, 1'b0, 2'd2, 1'b0};
    vecs[6]  = '{4'h7, 1'b0, 4'h2, 4'hF, 3'd1, 1'b1, 2'd2, 1'b0};
    vecs[7]  = '{4'h9, 1'b0, 4'h2, 4'hF, 3'd1, 1'b1, 2'd2, 1'b0};
    vecs[8]  = '{4'h4, 1'b1, 4'h2, 4'hF, 3'd4, 1'b0, 2'd3, 1'b1};
    vecs[9]  = '{4'h0, 1'b0, 4'h0, 4'hF, 3'd4, 1'b0, 2'd1, 1'b0};
    vecs[10] = '{4'h1, 1'b0, 4'h0, 4'h1, 3'd4, 1'b0, 2'd2, 1'b0};
    vecs[11] = '{4'h6, 1'b0, 4'h0, 4'h1, 3'd4, 1'b1, 2'd2, 1'b0};
    vecs[12] = '{4'h5, 1'b1, 4'h0, 4'h1, 3'd5, 1'b0, 2'd3, 1'b1};
    vecs[13] = '{4'hE, 1'b0, 4'hE, 4'h1, 3'd5, 1'b0, 2'd1, 1'b0};
    vecs[14] = '{4'hD, 1'b0, 4'hE, 4'hD, 3'd5, 1'b0, 2'd2, 1'b0};
    vecs[15] = '{4'h0, 1'b1, 4'hE, 4'hD, 3'd0, 1'b0, 2'd3, 1'b1};

    Resetn      = 1'b0;
    bus.Data    = 4'h0;
    bus.Load    = 1'b0;
    bus.Abort   = 1'b0;
    bus.OpReady = 1'b0;
    #12;
    check_all("reset", 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    // OpReady outside S_ISSUE does nothing
    pulse_ready();
    check_all("rdy_idle", 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0);

    // Table-driven sequences through the scoreboard
    for (int i = 0; i < 16; i++) begin
      sb_q.push_back(vecs[i]);
      do_load(vecs[i].data);
      exp_v = sb_q.pop_front();
      check_all($sformatf("vec%0d", i), exp_v.a, exp_v.b, exp_v.func,
                exp_v.valid, exp_v.err, exp_v.state, exp_cnt);
      if (exp_v.rdy) begin
        pulse_ready();
        exp_cnt = exp_cnt + 8'd1;
        check_all($sformatf("vec%0d_acc", i), exp_v.a, exp_v.b, exp_v.func,
                  1'b0, exp_v.err, 2'd0, exp_cnt);
      end
    end

    // Load held high for 20 cycles captures once
    @(negedge Clock);
    bus.Data = 4'h7;
    bus.Load = 1'b1;
    repeat (20) @(posedge Clock);
    @(negedge Clock);
    check_all("hold20", 4'h7, 4'hD, 3'd0, 1'b0, 1'b0, 2'd1, exp_cnt);
    bus.Load = 1'b0;
    repeat (4) @(posedge Clock);

    // Abort coincident with a load pulse in S_B
    @(negedge Clock);
    bus.Data = 4'hC;
    bus.Load = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.Load = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    bus.Abort = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.Abort = 1'b0;
    check_all("abort_b", 4'h7, 4'hD, 3'd0, 1'b0, 1'b0, 2'd0, exp_cnt);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_all("abort_b_late", 4'h7, 4'hD, 3'd0, 1'b0, 1'b0, 2'd0, exp_cnt);

    // Abort and OpReady together in S_ISSUE
    do_load(4'h1);
    do_load(4'h2);
    do_load(4'h3);
    check_all("pre_abort_iss", 4'h1, 4'h2, 3'd3, 1'b1, 1'b0, 2'd3, exp_cnt);
    @(negedge Clock);
    bus.Abort   = 1'b1;
    bus.OpReady = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.Abort   = 1'b0;
    bus.OpReady = 1'b0;
    check_all("abort_iss", 4'h1, 4'h2, 3'd3, 1'b0, 1'b0, 2'd0, exp_cnt);

    // Run sequences up to OpCount wrap
    while (exp_cnt != 8'hFF) begin
      do_load(4'h1);
      do_load(4'h2);
      do_load(4'h3);
      pulse_ready();
      exp_cnt = exp_cnt + 8'd1;
    end
    chk("cnt_ff", bus.OpCount, 8'hFF);
    do_load(4'h5);
    do_load(4'h6);
    do_load(4'h2);
    do_load(4'h9);   // ignored while issuing
    check_all("load_in_issue", 4'h5, 4'h6, 3'd2, 1'b1, 1'b0, 2'd3, 8'hFF);
    pulse_ready();
    exp_cnt = exp_cnt + 8'd1;
    check_all("cnt_wrap", 4'h5, 4'h6, 3'd2, 1'b0, 1'b0, 2'd0, exp_cnt);

    // Reset asserted in S_ISSUE clears everything before the next edge
    do_load(4'hF);
    do_load(4'hF);
    do_load(4'h2);
    check_all("pre_rst", 4'hF, 4'hF, 3'd2, 1'b1, 1'b0, 2'd3, 8'h00);
    @(posedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    check_all("async_rst", 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0);

    // Load held across reset release gives exactly one capture at edge 3
    bus.Data = 4'h6;
    bus.Load = 1'b1;
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check_all("rel_e2", 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0);
    @(posedge Clock);
    @(negedge Clock);
    check_all("rel_e3", 4'h6, 4'h0, 3'd0, 1'b0, 1'b0, 2'd1, 8'd0);
    repeat (10) @(posedge Clock);
    @(negedge Clock);
    check_all("rel_hold", 4'h6, 4'h0, 3'd0, 1'b0, 1'b0, 2'd1, 8'd0);
    bus.Load = 1'b0;
    repeat (2) @(posedge Clock);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
